tank_level_model: RTL and testbench



---
 rtl/tank_level_model.sv | 149 ++++++++++++++
 tb/tb_tank_level_model.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tank_level_model.sv
// Water-tank plant model for the two-pump controller: integer level, hysteretic I/S sensors, sticky clip flags.
// Define TANK_LEVEL_MODEL_RUNTIME_EN to add saturating per-pump runtime counters (b1_runtime, b2_runtime).
module tank_level_model #(
  parameter int LEVEL_W    = 8,
  parameter int LEVEL_MAX  = 200,
  parameter int INIT_LEVEL = 150,
  parameter int LOW_MARK   = 100,
  parameter int CRIT_MARK  = 40,
  parameter int HYST       = 10,
  parameter int FILL_RATE  = 3,
  parameter int DRAIN_RATE = 2,
  parameter int TICK_DIV   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               B1,
  input  logic               B2,
  input  logic               drain,
  input  logic               clr_flags,
  output logic               I,
  output logic               S,
  output logic [LEVEL_W-1:0] level,
  output logic               tick,
  output logic               overflow,
  output logic               dry
`ifdef TANK_LEVEL_MODEL_RUNTIME_EN
  ,
  output logic [15:0]        b1_runtime,
  output logic [15:0]        b2_runtime
`endif
);

  localparam int RAW_W   = LEVEL_W + 3;
  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [LEVEL_W-1:0] INIT_L     = LEVEL_W'(INIT_LEVEL);
  localparam logic [LEVEL_W-1:0] MAX_L      = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LOW_SET    = LEVEL_W'(LOW_MARK);
  localparam logic [LEVEL_W-1:0] LOW_CLR    = LEVEL_W'(LOW_MARK + HYST);
  localparam logic [LEVEL_W-1:0] CRIT_SET   = LEVEL_W'(CRIT_MARK);
  localparam logic [LEVEL_W-1:0] CRIT_CLR   = LEVEL_W'(CRIT_MARK + HYST);
  localparam logic               I_RST      = (INIT_LEVEL <= LOW_MARK);
  localparam logic               S_RST      = (INIT_LEVEL <= CRIT_MARK);

  localparam logic signed [RAW_W-1:0] FILL_S  = RAW_W'(FILL_RATE);
  localparam logic signed [RAW_W-1:0] DRAIN_S = RAW_W'(DRAIN_RATE);
  localparam logic signed [RAW_W-1:0] MAX_S   = RAW_W'(LEVEL_MAX);

  function automatic logic [LEVEL_W-1:0] clamp_level(input logic signed [RAW_W-1:0] raw);
    if (raw[RAW_W-1])
      return '0;
    else if (raw > MAX_S)
      return MAX_L;
    else
      return raw[LEVEL_W-1:0];
  endfunction

  function automatic logic hyst_sensor(input logic [LEVEL_W-1:0] lvl,
                                       input logic [LEVEL_W-1:0] set_at,
                                       input logic [LEVEL_W-1:0] clr_at,
                                       input logic               cur);
    if (lvl <= set_at)
      return 1'b1;
    else if (lvl >= clr_at)
      return 1'b0;
    else
      return cur;
  endfunction

  logic [PRESC_W-1:0]       presc_q, presc_d;
  logic [LEVEL_W-1:0]       level_q, level_d;
  logic                     i_q, i_d, s_q, s_d;
  logic                     ovf_q, ovf_d, dry_q, dry_d;
  logic                     tick_q;
  logic                     upd;
  logic signed [RAW_W-1:0]  raw_s;

  always_comb begin
    upd     = (presc_q == PRESC_LAST);
    presc_d = upd ? '0 : presc_q + 1'b1;
    raw_s   = signed'({3'b000, level_q}) + (B1 ? FILL_S : '0) + (B2 ? FILL_S : '0)
              - (drain ? DRAIN_S : '0);
    level_d = level_q;
    i_d     = i_q;
    s_d     = s_q;
    // Clear first so a same-edge clip re-sets the flag
    ovf_d   = clr_flags ? 1'b0 : ovf_q;
    dry_d   = clr_flags ? 1'b0 : dry_q;
    if (upd) begin
      level_d = clamp_level(raw_s);
      i_d     = hyst_sensor(level_d, LOW_SET, LOW_CLR, i_q);
      s_d     = hyst_sensor(level_d, CRIT_SET, CRIT_CLR, s_q);
      if (raw_s > MAX_S) ovf_d = 1'b1;
      if (raw_s[RAW_W-1]) dry_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      level_q <= INIT_L;
      i_q     <= I_RST;
      s_q     <= S_RST;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dry_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      level_q <= level_d;
      i_q     <= i_d;
      s_q     <= s_d;
      tick_q  <= upd;
      ovf_q   <= ovf_d;
      dry_q   <= dry_d;
    end
  end

  assign level    = level_q;
  assign I        = i_q;
  assign S        = s_q;
  assign tick     = tick_q;
  assign overflow = ovf_q;
  assign dry      = dry_q;

`ifdef TANK_LEVEL_MODEL_RUNTIME_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [15:0] b1_rt_q, b2_rt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      b1_rt_q <= '0;
      b2_rt_q <= '0;
    end else if (upd) begin
      if (B1) b1_rt_q <= sat_inc(b1_rt_q);
      if (B2) b2_rt_q <= sat_inc(b2_rt_q);
    end
  end

  assign b1_runtime = b1_rt_q;
  assign b2_runtime = b2_rt_q;
`else
  // Without runtime counters the pump inputs only influence the level.
`endif

endmodule

// File: tb/tb_tank_level_model.sv
// Directed testbench for tank_level_model with default parameters (TICK_DIV=4, fill 3, drain 2).
module tb_tank_level_model;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       B1 = 1'b0, B2 = 1'b0, drain = 1'b0, clr_flags = 1'b0;
  logic       I, S, tick, overflow, dry;
  logic [7:0] level;
`ifdef TANK_LEVEL_MODEL_RUNTIME_EN
  logic [15:0] b1_runtime, b2_runtime;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  tank_level_model dut (
    .clk(clk), .reset(reset), .B1(B1), .B2(B2), .drain(drain), .clr_flags(clr_flags),
    .I(I), .S(S), .level(level), .tick(tick), .overflow(overflow), .dry(dry)
`ifdef TANK_LEVEL_MODEL_RUNTIME_EN
    , .b1_runtime(b1_runtime), .b2_runtime(b2_runtime)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Waits on falling edges until tick is seen; returns cycles waited.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!tick && cycles < 20);
    if (!tick) check("tick_timeout", 0, 1);
  endtask

  task automatic ticks(input int n);
    int c;
    repeat (n) wait_tick(c);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_level", level, 150);
    check("rst_I", I, 0);
    check("rst_S", S, 0);
    check("rst_tick", tick, 0);
    check("rst_ovf", overflow, 0);
    check("rst_dry", dry, 0);

    // Pure drain from 150
    drain = 1'b1;
    wait_tick(cyc);
    check("first_tick_lat", cyc, 4);
    check("tick1_level", level, 148);
    @(negedge clk);
    check("tick_width", tick, 0);
    ticks(22);
    ticks(1);
    check("t24_level", level, 102);
    check("t24_I", I, 0);
    ticks(1);
    check("t25_level", level, 100);
    check("t25_I", I, 1);
    check("t25_S", S, 0);
    ticks(29);
    check("t54_level", level, 42);
    check("t54_S", S, 0);
    ticks(1);
    check("t55_level", level, 40);
    check("t55_S", S, 1);
    check("t55_I", I, 1);

    // Inputs between update edges are ignored
    B1 = 1'b1; B2 = 1'b1; drain = 1'b0;
    repeat (2) @(negedge clk);
    B1 = 1'b0; B2 = 1'b0; drain = 1'b1;
    wait_tick(cyc);
    check("ignore_mid_level", level, 38);

    // Drain to exactly 0 without clipping, then clip
    ticks(18);
    check("lvl2", level, 2);
    ticks(1);
    check("exact0_level", level, 0);
    check("exact0_dry", dry, 0);
    B1 = 1'b1;
    ticks(1);
    check("lvl1", level, 1);
    B1 = 1'b0;
    ticks(1);
    check("dry_level", level, 0);
    check("dry_set", dry, 1);
    ticks(1);
    check("dry_hold_level", level, 0);
    check("dry_hold", dry, 1);

    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check("dry_clr", dry, 0);

    // Clear and clip on the same update edge: set wins
    clr_flags = 1'b1;
    wait_tick(cyc);
    clr_flags = 1'b0;
    check("collide_dry", dry, 1);
    @(negedge clk);
    check("collide_dry_hold", dry, 1);
    check("collide_level", level, 0);

    // Hysteresis on I
    do_reset();
    drain = 1'b1;
    ticks(25);
    check("hy_start_level", level, 100);
    check("hy_start_I", I, 1);
    B1 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      ticks(1);
      check($sformatf("hy_lvl_%0d", 100 + k), level, 100 + k);
      check($sformatf("hy_I_%0d", 100 + k), I, 1);
    end
    ticks(1);
    check("hy_lvl_110", level, 110);
    check("hy_I_110", I, 0);

    // Overflow
    ticks(89);
    check("ovf_pre_level", level, 199);
    check("ovf_pre", overflow, 0);
    B2 = 1'b1; drain = 1'b0;
    ticks(1);
    check("ovf_level", level, 200);
    check("ovf_set", overflow, 1);
    ticks(1);
    check("ovf_hold_level", level, 200);
    check("ovf_hold", overflow, 1);
    B1 = 1'b0; B2 = 1'b0;
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check("ovf_clr", overflow, 0);
    ticks(1);
    check("ovf_after_level", level, 200);
    check("ovf_after", overflow, 0);

    // Re-set overflow, then walk down to 87 and reset mid-tick
    B1 = 1'b1;
    ticks(1);
    check("ovf_reset_pre", overflow, 1);
    B1 = 1'b0; drain = 1'b1;
    ticks(57);
    check("lvl86", level, 86);
    B1 = 1'b1;
    ticks(1);
    check("lvl87", level, 87);
    check("lvl87_I", I, 1);
    check("lvl87_S", S, 0);
    B1 = 1'b0; drain = 1'b0;
    @(negedge clk);
    do_reset();
    check("mid_rst_level", level, 150);
    check("mid_rst_I", I, 0);
    check("mid_rst_S", S, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_dry", dry, 0);
    check("mid_rst_tick", tick, 0);
    wait_tick(cyc);
    check("mid_rst_tick_lat", cyc, 4);
    check("mid_rst_tick_level", level, 150);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
